// File: rtl/ysyx_22040088_exec_sequencer.sv
// Multi-cycle instruction sequencer: IF -> ID -> EX -> [MEM] -> WB.
// Gates IR latch, register-file write, PC update and LSU requests, guards
// the IF/MEM handshakes with a stall timeout and counts retired instructions.
module ysyx_22040088_exec_sequencer #(
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req,
  input  logic             ifu_ready,
  output logic             ir_we,
  input  logic             dec_inv,
  input  logic             dec_ebreak,
  input  logic             dec_rf_we,
  input  logic             dec_mem_ena,
  input  logic             dec_mem_wen,
  output logic             lsu_req,
  output logic             lsu_wen,
  input  logic             lsu_ack,
  output logic             rf_we,
  output logic             pc_we,
  output logic             halt,
  output logic             err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IF;
      to_q      <= '0;
      err_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      to_q      <= to_d;
      err_q     <= err_d;
      instret_q <= instret_d;
    end
  end

  // Next-state, timeout and retirement logic.
  always_comb begin
    state_d   = state_q;
    to_d      = to_q;
    err_d     = err_q;
    instret_d = instret_q;
    unique case (state_q)
      S_IF: begin
        // A handshake on the limit cycle still wins over the timeout.
        if (ifu_ready) begin
          state_d = S_ID;
        end else if (to_q == TO_LIMIT) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_ID: begin
        if (dec_inv) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else if (dec_ebreak) begin
          state_d   = S_HALT;
          instret_d = instret_q + CNT_W'(1);
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (dec_mem_ena) begin
          state_d = S_MEM;
          to_d    = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (lsu_ack) begin
          state_d = S_WB;
        end else if (to_q == TO_LIMIT) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_WB: begin
        state_d   = S_IF;
        to_d      = '0;
        instret_d = instret_q + CNT_W'(1);
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        // Unreachable encodings 6/7 fall into an error halt.
        state_d = S_HALT;
        err_d   = 1'b1;
      end
    endcase
  end

  // Moore outputs from the registered state; ir_we also follows ifu_ready.
  always_comb begin
    ifu_req = 1'b0;
    ir_we   = 1'b0;
    lsu_req = 1'b0;
    lsu_wen = 1'b0;
    rf_we   = 1'b0;
    pc_we   = 1'b0;
    halt    = 1'b0;
    unique case (state_q)
      S_IF: begin
        ifu_req = 1'b1;
        ir_we   = ifu_ready;
      end
      S_MEM: begin
        lsu_req = 1'b1;
        lsu_wen = dec_mem_wen;
      end
      S_WB: begin
        rf_we = dec_rf_we;
        pc_we = 1'b1;
      end
      S_HALT: begin
        halt = 1'b1;
      end
      default: begin
        halt = 1'b0;
      end
    endcase
  end

  assign err     = err_q;
  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_ysyx_22040088_exec_sequencer.sv
// Bench for the exec sequencer: directed literal checks followed by random
// stimulus, all outputs compared every cycle against a behavioural model.
module tb_ysyx_22040088_exec_sequencer;

  localparam int CW   = 2;
  localparam int TOW  = 3;
  localparam int TOUT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req, ifu_ready, ir_we;
  logic          dec_inv, dec_ebreak, dec_rf_we, dec_mem_ena, dec_mem_wen;
  logic          lsu_req, lsu_wen, lsu_ack;
  logic          rf_we, pc_we, halt, err;
  logic [2:0]    state;
  logic [CW-1:0] instret;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: stage number as in the spec table, cycles already waited, flags.
  int m_st      = 0;
  int m_wait    = 0;
  int m_err     = 0;
  int m_instret = 0;
  bit m_known   = 1'b0;

  always #5 clk = ~clk;

  ysyx_22040088_exec_sequencer #(
    .CNT_W  (CW),
    .TO_W   (TOW),
    .TIMEOUT(TOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ifu_req    (ifu_req),
    .ifu_ready  (ifu_ready),
    .ir_we      (ir_we),
    .dec_inv    (dec_inv),
    .dec_ebreak (dec_ebreak),
    .dec_rf_we  (dec_rf_we),
    .dec_mem_ena(dec_mem_ena),
    .dec_mem_wen(dec_mem_wen),
    .lsu_req    (lsu_req),
    .lsu_wen    (lsu_wen),
    .lsu_ack    (lsu_ack),
    .rf_we      (rf_we),
    .pc_we      (pc_we),
    .halt       (halt),
    .err        (err),
    .state      (state),
    .instret    (instret)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: advance one instruction stage per clock.
  always @(posedge clk) begin
    if (!rst) begin
      m_st      = 0;
      m_wait    = 0;
      m_err     = 0;
      m_instret = 0;
      m_known   = 1'b1;
    end else if (m_known) begin
      case (m_st)
        0: begin
          if (ifu_ready) m_st = 1;
          else if (m_wait == TOUT) begin m_st = 5; m_err = 1; end
          else m_wait++;
        end
        1: begin
          if (dec_inv) begin m_st = 5; m_err = 1; end
          else if (dec_ebreak) begin m_st = 5; m_instret = (m_instret + 1) % (1 << CW); end
          else m_st = 2;
        end
        2: begin
          if (dec_mem_ena) begin m_st = 3; m_wait = 0; end
          else m_st = 4;
        end
        3: begin
          if (lsu_ack) m_st = 4;
          else if (m_wait == TOUT) begin m_st = 5; m_err = 1; end
          else m_wait++;
        end
        4: begin
          m_st = 0;
          m_wait = 0;
          m_instret = (m_instret + 1) % (1 << CW);
        end
        default: m_st = 5;
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      chk("state",   64'(state),   64'(m_st));
      chk("ifu_req", 64'(ifu_req), 64'(m_st == 0));
      chk("ir_we",   64'(ir_we),   64'(m_st == 0 && ifu_ready));
      chk("lsu_req", 64'(lsu_req), 64'(m_st == 3));
      chk("lsu_wen", 64'(lsu_wen), 64'(m_st == 3 && dec_mem_wen));
      chk("rf_we",   64'(rf_we),   64'(m_st == 4 && dec_rf_we));
      chk("pc_we",   64'(pc_we),   64'(m_st == 4));
      chk("halt",    64'(halt),    64'(m_st == 5));
      chk("err",     64'(err),     64'(m_err));
      chk("instret", 64'(instret), 64'(m_instret));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; ifu_ready = 1'b0; lsu_ack = 1'b0;
    dec_inv = 1'b0; dec_ebreak = 1'b0; dec_rf_we = 1'b0;
    dec_mem_ena = 1'b0; dec_mem_wen = 1'b0;
    tick(); tick();

    // ALU op
    rst = 1'b1; dec_rf_we = 1'b1; ifu_ready = 1'b1; #2;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_instret", 64'(instret), 64'd0);
    chk("rst_halt", 64'(halt), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("alu_irwe", 64'(ir_we), 64'd1);
    tick(); ifu_ready = 1'b0; #2;
    chk("alu_id", 64'(state), 64'd1);
    tick(); #2;
    chk("alu_ex", 64'(state), 64'd2);
    tick(); #2;
    chk("alu_wb", 64'(state), 64'd4);
    chk("alu_rfwe", 64'(rf_we), 64'd1);
    chk("alu_pcwe", 64'(pc_we), 64'd1);
    tick(); #2;
    chk("alu_if", 64'(state), 64'd0);
    chk("alu_instret", 64'(instret), 64'd1);

    // Load with ack in the 4th MEM cycle
    ifu_ready = 1'b1; dec_mem_ena = 1'b1; dec_mem_wen = 1'b0; dec_rf_we = 1'b1;
    tick(); ifu_ready = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      lsu_ack = (i == 3); #2;
      chk("ld_req", 64'(lsu_req), 64'd1);
      chk("ld_wen", 64'(lsu_wen), 64'd0);
      tick();
    end
    lsu_ack = 1'b0; #2;
    chk("ld_wb", 64'(state), 64'd4);
    chk("ld_rfwe", 64'(rf_we), 64'd1);
    chk("ld_req_off", 64'(lsu_req), 64'd0);
    tick(); #2;
    chk("ld_instret", 64'(instret), 64'd2);

    // Store with immediate ack
    ifu_ready = 1'b1; dec_mem_wen = 1'b1; dec_rf_we = 1'b0;
    tick(); ifu_ready = 1'b0;
    tick(); tick();
    lsu_ack = 1'b1; #2;
    chk("st_wen", 64'(lsu_wen), 64'd1);
    tick(); lsu_ack = 1'b0; #2;
    chk("st_wb", 64'(state), 64'd4);
    chk("st_rfwe", 64'(rf_we), 64'd0);
    chk("st_pcwe", 64'(pc_we), 64'd1);
    tick(); #2;
    chk("st_instret", 64'(instret), 64'd3);

    // Two more ALU ops: 5 retirements wrap a 2-bit counter to 1
    dec_mem_ena = 1'b0; dec_mem_wen = 1'b0; dec_rf_we = 1'b1;
    repeat (2) begin
      ifu_ready = 1'b1; tick(); ifu_ready = 1'b0; tick(); tick(); tick();
    end
    #2;
    chk("wrap_instret", 64'(instret), 64'd1);

    // Reset while waiting in MEM
    ifu_ready = 1'b1; dec_mem_ena = 1'b1;
    tick(); ifu_ready = 1'b0; tick(); tick(); #2;
    chk("rm_inmem", 64'(state), 64'd3);
    rst = 1'b0;
    tick(); rst = 1'b1; #2;
    chk("rm_state", 64'(state), 64'd0);
    chk("rm_lsureq", 64'(lsu_req), 64'd0);
    chk("rm_instret", 64'(instret), 64'd0);

    // Fetch timeout: 5 IF cycles without ready
    repeat (4) tick();
    #2;
    chk("to_if5", 64'(state), 64'd0);
    tick(); #2;
    chk("to_halt", 64'(state), 64'd5);
    chk("to_err", 64'(err), 64'd1);

    // Ready on the boundary cycle wins
    rst = 1'b0; tick(); rst = 1'b1;
    repeat (4) tick();
    ifu_ready = 1'b1; #2;
    chk("bd_irwe", 64'(ir_we), 64'd1);
    tick(); ifu_ready = 1'b0; dec_inv = 1'b1; #2;
    chk("bd_id", 64'(state), 64'd1);
    chk("bd_err", 64'(err), 64'd0);

    // Invalid instruction halt
    tick(); dec_inv = 1'b0; #2;
    chk("inv_state", 64'(state), 64'd5);
    chk("inv_err", 64'(err), 64'd1);
    chk("inv_instret", 64'(instret), 64'd0);

    // Ebreak halt, later fetch pulses ignored
    rst = 1'b0; tick(); rst = 1'b1;
    ifu_ready = 1'b1; dec_ebreak = 1'b1; dec_mem_ena = 1'b0;
    tick(); ifu_ready = 1'b0;
    tick(); #2;
    chk("eb_halt", 64'(halt), 64'd1);
    chk("eb_err", 64'(err), 64'd0);
    chk("eb_instret", 64'(instret), 64'd1);
    ifu_ready = 1'b1; #2;
    chk("eb_irwe", 64'(ir_we), 64'd0);
    chk("eb_ifureq", 64'(ifu_req), 64'd0);
    tick(); #2;
    chk("eb_stay", 64'(state), 64'd5);
    ifu_ready = 1'b0; dec_ebreak = 1'b0;

    // Random phase
    rst = 1'b0; tick(); rst = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (m_st == 5) rst = ($urandom % 4 != 0);
      else           rst = ($urandom % 300 != 0);
      ifu_ready = ($urandom % 2 == 0);
      lsu_ack   = ($urandom % 2 == 0);
      if (m_st == 0) begin
        dec_inv     = ($urandom % 16 == 0);
        dec_ebreak  = ($urandom % 12 == 0);
        dec_rf_we   = ($urandom % 2 == 0);
        dec_mem_ena = ($urandom % 2 == 0);
        dec_mem_wen = ($urandom % 2 == 0);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22040088_exec_sequencer.md
Name: ysyx_22040088_exec_sequencer

Overview:
- Multi-cycle instruction sequencer for the ysyx_22040088 core.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Gates the instruction-register latch, register-file write, PC update and LSU requests, using the control signals produced by the decode stage.
- Handles instruction-fetch and data-memory handshakes, stall timeouts, illegal-instruction and ebreak halts, and counts retired instructions.

Parameters:
CNT_W, 64, width of retired-instruction counter
TO_W, 8, width of stall timeout counter
TIMEOUT, 255, max wait cycles in IF or MEM before error halt (must fit in TO_W)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous active-low reset (0 = reset, sampled on rising clk)
ifu_req  output  1  request next instruction from fetch unit
ifu_ready  input  1  fetched instruction valid this cycle
ir_we  output  1  latch instruction into IR (decode inputs stable from next cycle)
dec_inv  input  1  decoder: invalid instruction
dec_ebreak  input  1  decoder: ebreak
dec_rf_we  input  1  decoder: instruction writes rd
dec_mem_ena  input  1  decoder: instruction accesses memory
dec_mem_wen  input  1  decoder: memory access is a store
lsu_req  output  1  data memory request
lsu_wen  output  1  data memory write (valid with lsu_req)
lsu_ack  input  1  data memory access complete
rf_we  output  1  register-file write enable
pc_we  output  1  PC register update enable
halt  output  1  core halted
err  output  1  halted on error (invalid instruction or timeout)
state  output  3  current state encoding, for debug
instret  output  CNT_W  retired-instruction count

Behaviour:
- States and encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 are illegal; they go to HALT with err=1.
- Reset (rst=0 at a clk edge):
  - state=IF, instret=0, timeout counter=0, halt=0, err=0.
  - Overrides any state, including mid-MEM or HALT. Outstanding requests drop in the cycle after the reset edge.
- Output decoding:
  - ifu_req=1 only in IF; lsu_req=1 only in MEM; rf_we and pc_we are driven only in WB.
  - ir_we = (state==IF) & ifu_ready, combinational.
  - All other outputs are Moore (registered state only).
- IF: wait for ifu_ready. When ifu_ready=1, assert ir_we the same cycle and go to ID next.
- ID (1 cycle):
  - dec_inv=1 -> HALT, err=1, no increment.
  - else dec_ebreak=1 -> HALT, err=0, instret+1.
  - else -> EX.
  - dec_inv has priority over dec_ebreak.
- EX (1 cycle, ALU settle): dec_mem_ena=1 -> MEM, else -> WB.
- MEM:
  - lsu_req=1; lsu_wen=dec_mem_wen, held constant for the whole request.
  - Stay until lsu_ack=1, then go to WB. An ack arriving in the first MEM cycle is accepted.
- WB (1 cycle): rf_we=dec_rf_we, pc_we=1, instret+1, -> IF.
- HALT: absorbing until reset. halt=1, err held, all request and enable outputs 0.
- Timeout counter:
  - Cleared on entry to IF or MEM; increments each cycle the awaited handshake is absent.
  - If it equals TIMEOUT while still waiting -> HALT, err=1, no increment.
  - A handshake in the same cycle the counter reaches TIMEOUT wins: normal transition, no error.
- ifu_ready outside IF and lsu_ack outside MEM are ignored.
- instret wraps modulo 2^CNT_W.
- Decoder inputs are sampled only in ID, EX, MEM and WB. They must stay stable from the cycle after ir_we until leaving WB; the IR holds them.
- Minimum latency per instruction:
  - ALU instruction: 4 cycles (IF with immediate ready, ID, EX, WB).
  - Memory instruction: 5 cycles.

Test Plan:
- ALU op: release reset; ifu_ready=1 in first IF cycle, dec_rf_we=1, dec_mem_ena=0 -> states 0,1,2,4,0; rf_we=pc_we=1 in cycle 4; instret=1.
- Load with delay: dec_mem_ena=1, dec_mem_wen=0, lsu_ack 3 cycles after MEM entry -> lsu_req high for 4 cycles, lsu_wen=0; then WB with rf_we=1; instret+1.
- Store: dec_mem_wen=1, dec_rf_we=0, immediate ack -> lsu_wen=1 for one MEM cycle; WB with rf_we=0, pc_we=1.
- Halts:
  - dec_inv=1 in ID -> HALT next cycle, halt=1, err=1, instret unchanged.
  - Separate run: dec_ebreak=1 -> halt=1, err=0, instret+1; ifu_ready pulses afterwards produce no ir_we.
- Timeout: TIMEOUT=4, ifu_ready held 0 -> HALT with err=1 after the 5th IF cycle. Repeat with ifu_ready=1 on the boundary cycle -> normal ID.
- Reset and wrap:
  - rst=0 for one cycle mid-MEM -> next cycle state=IF, lsu_req=0, instret=0.
  - CNT_W=2, 5 WB retirements -> instret=1.
